// File: rtl/prog_loader.sv
// prog_loader: program loader sitting upstream of the processor.
//
// Accepts 32-bit instruction words over a valid/ready handshake and writes
// them into instruction RAM at consecutive addresses through the processor's
// addr/wr/wdata inputs. Words whose {icode,ifun} is not one of the legal
// opcodes are never written; they push the loader into a sticky error state.
// Once the final word has been written, one COMMIT cycle lets that write
// land before working is raised and the processor takes over the address bus.
//
// Optional feature (macro LOADER_CHKSUM_EN): a running XOR of every written
// word is kept, and one extra checksum word must follow the in_last word.
// A matching checksum lets the load commit; a mismatch is an error.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   load_start pulse: start a new load at address 0 (from any state)
//   run_stop   pulse: leave RUN and return to IDLE
//   in_valid   in_data holds a word
//   in_ready   loader accepts a word this cycle (registered)
//   in_data    instruction word {icode,ifun,rA,rB,valC}
//   in_last    marks in_data as the final program word
//   addr       RAM address
//   wr         RAM write strobe (one cycle per word)
//   wdata      RAM write data
//   working    processor run enable
//   prog_len   number of words written by the last load
//   error      sticky load error (illegal opcode, overflow, bad checksum)

module prog_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              run_stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [ADDR_W-1:0] addr,
  output logic              wr,
  output logic [DATA_W-1:0] wdata,
  output logic              working,
  output logic [ADDR_W:0]   prog_len,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMMIT,
    RUN,
    ERR
`ifdef LOADER_CHKSUM_EN
    , CHK
`endif
  } LoaderState;

  // Pointer is one bit wider than the address so a full DEPTH can be counted.
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W+1)'(DEPTH);

  LoaderState        state;
  logic [ADDR_W:0]   ptr;
  logic [ADDR_W:0]   ptrInc;
  logic [7:0]        opcode;
  logic              legalOp;
  logic              accept;

`ifdef LOADER_CHKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  // Opcode screening and handshake qualification, shared by the FSM below.
  assign ptrInc  = ptr + {{ADDR_W{1'b0}}, 1'b1};
  assign opcode  = in_data[DATA_W-1 -: 8];
  assign legalOp = opcode inside {8'h10, 8'h20, 8'h21, 8'h22, 8'h23};
  assign accept  = in_valid && in_ready;

  // Single FSM block with every output registered. in_ready is decided at
  // the same edge that decides the next state and pointer, so it always
  // reflects the state/pointer it will be observed with. wr defaults low so
  // each accepted word yields exactly one strobe; an in-flight strobe still
  // completes when load_start restarts the load, because it is already in
  // the register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      addr     <= '0;
      wr       <= 1'b0;
      wdata    <= '0;
      working  <= 1'b0;
      in_ready <= 1'b0;
      prog_len <= '0;
      error    <= 1'b0;
`ifdef LOADER_CHKSUM_EN
      csum     <= '0;
`endif
    end else begin
      wr <= 1'b0;
      if (load_start) begin
        // load_start beats run_stop and any in-progress load.
        state    <= LOAD;
        ptr      <= '0;
        prog_len <= '0;
        error    <= 1'b0;
        working  <= 1'b0;
        in_ready <= (DepthLim != '0);
`ifdef LOADER_CHKSUM_EN
        csum     <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
          end

          LOAD: begin
            if (ptr == DepthLim) begin
              // Program filled the RAM without an in_last word.
              in_ready <= 1'b0;
              error    <= 1'b1;
              state    <= ERR;
            end else if (accept) begin
              if (legalOp) begin
                wr       <= 1'b1;
                addr     <= ptr[ADDR_W-1:0];
                wdata    <= in_data;
                ptr      <= ptrInc;
                prog_len <= ptrInc;
`ifdef LOADER_CHKSUM_EN
                csum     <= csum ^ in_data;
`endif
                if (in_last) begin
`ifdef LOADER_CHKSUM_EN
                  state    <= CHK;
                  in_ready <= 1'b1;
`else
                  state    <= COMMIT;
                  in_ready <= 1'b0;
`endif
                end else begin
                  in_ready <= (ptrInc < DepthLim);
                end
              end else begin
                in_ready <= 1'b0;
                error    <= 1'b1;
                state    <= ERR;
              end
            end
          end

`ifdef LOADER_CHKSUM_EN
          CHK: begin
            // The checksum word skips opcode screening and is never written.
            if (accept) begin
              in_ready <= 1'b0;
              if (in_data == csum) begin
                state <= COMMIT;
              end else begin
                error <= 1'b1;
                state <= ERR;
              end
            end
          end
`endif

          COMMIT: begin
            // The last write lands this cycle; only then hand over the bus.
            state   <= RUN;
            working <= 1'b1;
            addr    <= '0;
          end

          RUN: begin
            if (run_stop) begin
              state   <= IDLE;
              working <= 1'b0;
            end
          end

          ERR: begin
          end

          default: begin
            state    <= IDLE;
            in_ready <= 1'b0;
            working  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader.
//
// Two loaders share all inputs: dutA with the default DEPTH of 512 and dutB
// with DEPTH=4 for the overflow scenario. Expected RAM writes, prog_len,
// error and working come from a list-level model that walks the program
// word by word. Honours LOADER_CHKSUM_EN the same way the design does.

module tb_prog_loader;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clock;
  logic          reset;
  logic          load_start;
  logic          run_stop;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;

  logic          aInReady, aWr, aWorking, aError;
  logic [AW-1:0] aAddr;
  logic [DW-1:0] aWdata;
  logic [AW:0]   aProgLen;
  logic          bInReady, bWr, bWorking, bError;
  logic [AW-1:0] bAddr;
  logic [DW-1:0] bWdata;
  logic [AW:0]   bProgLen;

  prog_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(512)) dutA (
    .clock(clock), .reset(reset), .load_start(load_start), .run_stop(run_stop),
    .in_valid(in_valid), .in_ready(aInReady), .in_data(in_data), .in_last(in_last),
    .addr(aAddr), .wr(aWr), .wdata(aWdata), .working(aWorking),
    .prog_len(aProgLen), .error(aError)
  );

  prog_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4)) dutB (
    .clock(clock), .reset(reset), .load_start(load_start), .run_stop(run_stop),
    .in_valid(in_valid), .in_ready(bInReady), .in_data(in_data), .in_last(in_last),
    .addr(bAddr), .wr(bWr), .wdata(bWdata), .working(bWorking),
    .prog_len(bProgLen), .error(bError)
  );

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every write strobe as {addr, wdata}, sampled mid-cycle.
  logic [AW+DW-1:0] aWrQ[$];
  logic [AW+DW-1:0] bWrQ[$];
  always @(negedge clock) begin
    if (aWr === 1'b1) aWrQ.push_back({aAddr, aWdata});
    if (bWr === 1'b1) bWrQ.push_back({bAddr, bWdata});
  end

  int nTests;
  int nFail;

  // Program under test and the model's predictions for it.
  logic [DW-1:0]    prog[$];
  bit               progHasLast;
  logic [AW+DW-1:0] expWrQ[$];
  bit               expErr;
  bit               expRun;
  int               expLen;
  int               expAccepts;
  logic [DW-1:0]    goodChk;
  logic [DW-1:0]    chkSent;
  bit               chkUseFixed;
  logic [DW-1:0]    chkFixed;

  logic [7:0] legalOps [5] = '{8'h10, 8'h20, 8'h21, 8'h22, 8'h23};

  function automatic bit isLegal(input logic [7:0] op);
    return op inside {8'h10, 8'h20, 8'h21, 8'h22, 8'h23};
  endfunction

  // Index of the first entry where a recorded write list differs from the
  // expected one, or -1 when they are identical.
  function automatic int firstDiff(input logic [AW+DW-1:0] q[$]);
    int n = (q.size() < expWrQ.size()) ? q.size() : expWrQ.size();
    for (int i = 0; i < n; i++) if (q[i] !== expWrQ[i]) return i;
    if (q.size() != expWrQ.size()) return n;
    return -1;
  endfunction

  // Reference model: walk the program as a list. Legal words land at their
  // index until the RAM is full, an illegal word is met, or in_last ends it.
  task automatic computeExpected(input int depth);
    expWrQ.delete();
    expErr = 0; expRun = 0; expLen = 0; expAccepts = 0; goodChk = '0;
    for (int i = 0; i < prog.size(); i++) begin
      if (i == depth) begin expErr = 1; return; end
      expAccepts++;
      if (!isLegal(prog[i][31:24])) begin expErr = 1; return; end
      expWrQ.push_back({i[AW-1:0], prog[i]});
      expLen++;
      goodChk = goodChk ^ prog[i];
      if (progHasLast && i == prog.size() - 1) begin
        chkSent = chkUseFixed ? chkFixed : goodChk;
`ifdef LOADER_CHKSUM_EN
        expAccepts++;
        if (chkSent != goodChk) begin expErr = 1; return; end
`endif
        expRun = 1;
      end
    end
    if (!progHasLast && expLen == depth) expErr = 1;
  endtask

  task automatic startLoad();
    @(posedge clock); #1;
    aWrQ.delete(); bWrQ.delete();
    @(negedge clock); load_start = 1'b1;
    @(negedge clock); load_start = 1'b0;
  endtask

  // Stream the words the model says will be accepted. gapMode: 0 none,
  // 1 valid on alternate cycles, 2 random gaps. Returns just after the
  // edge that accepted the final word.
  task automatic sendProgram(input bit useB, input int gapMode);
    int idx = 0;
    int budget = 0;
    bit valid, rdy;
    while (idx < expAccepts) begin
      @(negedge clock);
      case (gapMode)
        0:       valid = 1'b1;
        1:       valid = (budget % 2 == 1);
        default: valid = ($urandom_range(0, 1) == 1);
      endcase
      in_valid = valid;
      in_data  = (idx < prog.size()) ? prog[idx] : chkSent;
      in_last  = progHasLast && (idx == prog.size() - 1);
      rdy      = useB ? bInReady : aInReady;
      @(posedge clock);
      if (valid && rdy) idx++;
      budget++;
      if (budget > 400) begin
        nTests++; nFail++;
        $display("[TB] FAIL send_timeout: accepted %0d words, required %0d", idx, expAccepts);
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic nominalProgram();
    prog = '{32'h10F00080, 32'h10F10081, 32'h10F20082, 32'h10F30083,
             32'h20010000, 32'h21230000, 32'h22450000, 32'h23670000};
    progHasLast = 1;
    chkUseFixed = 0;
  endtask

  task automatic applyStimulus();
    reset = 1'b0; load_start = 1'b0; run_stop = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    chkUseFixed = 0; chkFixed = '0; chkSent = '0;
  endtask

  // Asynchronous reset clears every output without a clock edge.
  task automatic test_reset();
    #2 reset = 1'b1;
    #2;
    nTests++;
    if ({aInReady, aWr, aWorking, aError} !== 4'b0) begin
      nFail++;
      $display("[TB] FAIL reset_flags: got rdy/wr/work/err=%b, required 0000",
               {aInReady, aWr, aWorking, aError});
    end
    nTests++;
    if ({aAddr, aWdata, aProgLen} !== '0) begin
      nFail++;
      $display("[TB] FAIL reset_values: got addr=%h wdata=%h len=%0d, required 0",
               aAddr, aWdata, aProgLen);
    end
    @(negedge clock) reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_load(input int gapMode);
    nominalProgram();
    computeExpected(512);
    startLoad();
    sendProgram(0, gapMode);
    @(negedge clock);
    nTests++;
    if (aWorking !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL working_early(gap%0d): got %b, required 0", gapMode, aWorking);
    end
    @(negedge clock);
    nTests++;
    if (aWorking !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL working_rise(gap%0d): got %b, required 1", gapMode, aWorking);
    end
    repeat (3) @(negedge clock);
    nTests++;
    if (firstDiff(aWrQ) >= 0) begin
      nFail++;
      $display("[TB] FAIL writes(gap%0d): got %0d writes, required %0d, first diff at %0d",
               gapMode, aWrQ.size(), expWrQ.size(), firstDiff(aWrQ));
    end
    nTests++;
    if ({aProgLen, aError, aInReady, aWorking, aAddr} !== {10'(expLen), 1'b0, 1'b0, 1'b1, 9'd0}) begin
      nFail++;
      $display("[TB] FAIL run_state(gap%0d): got len=%0d err=%b rdy=%b work=%b addr=%0d, required len=%0d err=0 rdy=0 work=1 addr=0",
               gapMode, aProgLen, aError, aInReady, aWorking, aAddr, expLen);
    end
    @(negedge clock) run_stop = 1'b1;
    @(negedge clock) run_stop = 1'b0;
    nTests++;
    if (aWorking !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL run_stop(gap%0d): got working=%b, required 0", gapMode, aWorking);
    end
  endtask

  task automatic test_illegal();
    nominalProgram();
    prog[3] = 32'h30F00000;
    computeExpected(512);
    startLoad();
    sendProgram(0, 0);
    repeat (4) @(negedge clock);
    nTests++;
    if (firstDiff(aWrQ) >= 0) begin
      nFail++;
      $display("[TB] FAIL illegal_writes: got %0d writes, required %0d", aWrQ.size(), expWrQ.size());
    end
    nTests++;
    if ({aError, aInReady, aWorking, aProgLen} !== {1'b1, 1'b0, 1'b0, 10'(expLen)}) begin
      nFail++;
      $display("[TB] FAIL illegal_state: got err=%b rdy=%b work=%b len=%0d, required err=1 rdy=0 work=0 len=%0d",
               aError, aInReady, aWorking, aProgLen, expLen);
    end
    prog = '{32'h10F00080, 32'h20010000};
    progHasLast = 1;
    computeExpected(512);
    startLoad();
    nTests++;
    if ({aError, aInReady} !== 2'b01) begin
      nFail++;
      $display("[TB] FAIL illegal_restart: got err=%b rdy=%b, required err=0 rdy=1", aError, aInReady);
    end
    sendProgram(0, 0);
    repeat (4) @(negedge clock);
    nTests++;
    if (firstDiff(aWrQ) >= 0 || aWorking !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL restart_writes: got %0d writes work=%b, required %0d writes work=1",
               aWrQ.size(), aWorking, expWrQ.size());
    end
  endtask

  task automatic test_overflow();
    nominalProgram();
    prog = prog[0:4];
    progHasLast = 0;
    computeExpected(4);
    startLoad();
    sendProgram(1, 0);
    @(negedge clock);
    nTests++;
    if ({bInReady, bError} !== 2'b00) begin
      nFail++;
      $display("[TB] FAIL overflow_ready: got rdy=%b err=%b, required rdy=0 err=0", bInReady, bError);
    end
    in_valid = 1'b1;
    in_data  = prog[4];
    @(negedge clock);
    nTests++;
    if (bError !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL overflow_error: got %b, required 1", bError);
    end
    repeat (3) @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    nTests++;
    if (firstDiff(bWrQ) >= 0 || bProgLen !== 10'(expLen) || bWorking !== 1'b0 || expErr != 1) begin
      nFail++;
      $display("[TB] FAIL overflow_writes: got %0d writes len=%0d work=%b, required %0d writes len=%0d work=0",
               bWrQ.size(), bProgLen, bWorking, expWrQ.size(), expLen);
    end
  endtask

  task automatic test_reset_mid();
    nominalProgram();
    prog = prog[0:1];
    progHasLast = 0;
    computeExpected(512);
    startLoad();
    sendProgram(0, 0);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    nTests++;
    if ({aInReady, aWr, aWorking, aError, aAddr, aWdata, aProgLen} !== '0) begin
      nFail++;
      $display("[TB] FAIL reset_mid: got rdy=%b wr=%b work=%b err=%b addr=%h wdata=%h len=%0d, required all 0",
               aInReady, aWr, aWorking, aError, aAddr, aWdata, aProgLen);
    end
    @(negedge clock) reset = 1'b0;
    nominalProgram();
    prog = prog[0:0];
    computeExpected(512);
    startLoad();
    sendProgram(0, 0);
    repeat (4) @(negedge clock);
    nTests++;
    if (firstDiff(aWrQ) >= 0 || aProgLen !== 10'd1 || aWorking !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL reset_reload: got %0d writes len=%0d work=%b, required 1 write len=1 work=1",
               aWrQ.size(), aProgLen, aWorking);
    end
    @(negedge clock) begin load_start = 1'b1; run_stop = 1'b1; end
    @(negedge clock) begin load_start = 1'b0; run_stop = 1'b0; end
    nTests++;
    if ({aWorking, aInReady} !== 2'b01) begin
      nFail++;
      $display("[TB] FAIL start_beats_stop: got work=%b rdy=%b, required work=0 rdy=1", aWorking, aInReady);
    end
  endtask

  task automatic test_random(input int rounds);
    int len, bad;
    logic [7:0] op;
    for (int r = 0; r < rounds; r++) begin
      len = $urandom_range(1, 12);
      prog.delete();
      for (int i = 0; i < len; i++)
        prog.push_back({legalOps[$urandom_range(0, 4)], 24'($urandom)});
      if ($urandom_range(0, 3) == 0) begin
        bad = $urandom_range(0, len - 1);
        op = 8'($urandom);
        while (isLegal(op)) op = 8'($urandom);
        prog[bad][31:24] = op;
      end
      progHasLast = 1;
`ifdef LOADER_CHKSUM_EN
      chkUseFixed = ($urandom_range(0, 3) == 0);
      chkFixed    = $urandom;
`endif
      computeExpected(512);
      startLoad();
      sendProgram(0, $urandom_range(0, 2));
      repeat (4) @(negedge clock);
      nTests++;
      if (firstDiff(aWrQ) >= 0) begin
        nFail++;
        $display("[TB] FAIL random%0d_writes: got %0d writes, required %0d, first diff at %0d",
                 r, aWrQ.size(), expWrQ.size(), firstDiff(aWrQ));
      end
      nTests++;
      if ({aError, aWorking, aProgLen} !== {expErr, expRun, 10'(expLen)}) begin
        nFail++;
        $display("[TB] FAIL random%0d_state: got err=%b work=%b len=%0d, required err=%b work=%b len=%0d",
                 r, aError, aWorking, aProgLen, expErr, expRun, expLen);
      end
    end
    chkUseFixed = 0;
  endtask

`ifdef LOADER_CHKSUM_EN
  task automatic test_chksum();
    prog = '{32'h10F00080, 32'h20010000};
    progHasLast = 1;
    chkUseFixed = 1;
    chkFixed    = 32'h30F10080;
    computeExpected(512);
    startLoad();
    sendProgram(0, 0);
    repeat (4) @(negedge clock);
    nTests++;
    if ({aWorking, aError} !== 2'b10) begin
      nFail++;
      $display("[TB] FAIL chksum_good: got work=%b err=%b, required work=1 err=0", aWorking, aError);
    end
    chkFixed = 32'h00000000;
    computeExpected(512);
    startLoad();
    sendProgram(0, 0);
    repeat (4) @(negedge clock);
    nTests++;
    if ({aWorking, aError} !== 2'b01) begin
      nFail++;
      $display("[TB] FAIL chksum_bad: got work=%b err=%b, required work=0 err=1", aWorking, aError);
    end
    chkUseFixed = 0;
  endtask
`endif

  // Scenario sequence, then the summary line.
  initial begin
    nTests = 0;
    nFail  = 0;
    applyStimulus();
    test_reset();
    test_load(0);
    test_load(1);
    test_illegal();
    test_overflow();
    test_reset_mid();
    test_random(20);
`ifdef LOADER_CHKSUM_EN
    test_chksum();
`endif
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  // Hard stop in case a scenario wedges outside its own bounds.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
